// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory-port arbiter.
// Contents: default widths/timeout, FSM state encoding, last-grant
// encoding and the round-robin grant selection helper.
package mem_arb_pkg;

    localparam int DEF_DW      = 32;
    localparam int DEF_AW      = 32;
    localparam int DEF_TIMEOUT = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_DATA  = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    // Choose the requester to serve; on contention the one not served last wins.
    function automatic grant_t pick_grant(input logic if_req_in,
                                          input logic d_req_in,
                                          input grant_t last);
        grant_t g;
        if (if_req_in && d_req_in) begin
            g = (last == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
        end else if (d_req_in) begin
            g = GRANT_DATA;
        end else begin
            g = GRANT_FETCH;
        end
        return g;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_wait_timer.sv
// wait_timer: 8-bit wait-cycle counter for one memory access.
// Ports:
//   clk, reset   - clock, asynchronous active-low reset
//   i_clear      - return the count to zero (wins over i_en)
//   i_en         - advance the count by one
//   o_expired    - count currently equals TIMEOUT
module wait_timer
    import mem_arb_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_en,
    output logic o_expired
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] r_count;

    // Wait-cycle counter register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_en) begin
            r_count <= r_count + 8'd1;
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expired = (r_count == LIMIT);

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between an instruction-fetch
// requester and a data load/store requester.
// Ports:
//   clk, reset                        - clock, asynchronous active-low reset
//   if_req, if_addr                   - fetch request (level, held until if_done)
//   d_req, d_we, d_addr, d_wdata      - data request (level, held until d_done)
//   if_done, d_done                   - one-cycle completion pulses
//   rdata                             - data of the last completed read
//   mem_en, mem_we, mem_addr,
//   mem_wdata                         - memory port command (registered)
//   mem_rdata, mem_ready              - memory read data and access-complete
//   err                               - sticky timeout flag
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DW      = DEF_DW,
    parameter int AW      = DEF_AW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          if_done,
    output logic          d_done,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ready,
    output logic          err
);

    arb_state_t    r_state;
    arb_state_t    w_next_state;
    grant_t        r_last_grant;
    grant_t        w_sel;
    logic          w_grant;
    logic          w_finish;
    logic          w_timeout;
    logic          w_timer_clear;
    logic          w_timer_en;
    logic          w_expired;

    logic          r_if_done;
    logic          r_d_done;
    logic [DW-1:0] r_rdata;
    logic          r_mem_en;
    logic          r_mem_we;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_err;

    wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .reset     (reset),
        .i_clear   (w_timer_clear),
        .i_en      (w_timer_en),
        .o_expired (w_expired)
    );

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode: grant in IDLE, completion/timeout in FETCH/DATA.
    always_comb begin
        w_next_state  = r_state;
        w_sel         = GRANT_FETCH;
        w_grant       = 1'b0;
        w_finish      = 1'b0;
        w_timeout     = 1'b0;
        w_timer_clear = 1'b0;
        w_timer_en    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // A done pulse still visible means the requester has not yet
                // had a chance to drop its request; hold off one cycle.
                if (!r_if_done && !r_d_done && (if_req || d_req)) begin
                    w_grant       = 1'b1;
                    w_sel         = pick_grant(if_req, d_req, r_last_grant);
                    w_next_state  = (w_sel == GRANT_DATA) ? ST_DATA : ST_FETCH;
                    w_timer_clear = 1'b1;
                end else begin
                    w_next_state  = ST_IDLE;
                end
            end
            ST_FETCH, ST_DATA: begin
                // Ready is checked before the limit so ready on the last
                // allowed cycle still counts as success.
                if (mem_ready) begin
                    w_finish      = 1'b1;
                    w_timer_clear = 1'b1;
                    w_next_state  = ST_IDLE;
                end else if (w_expired) begin
                    w_finish      = 1'b1;
                    w_timeout     = 1'b1;
                    w_timer_clear = 1'b1;
                    w_next_state  = ST_IDLE;
                end else begin
                    w_timer_en    = 1'b1;
                end
            end
            default: begin
                w_next_state  = ST_IDLE;
                w_timer_clear = 1'b1;
            end
        endcase
    end

    // Output registers: command latch at grant, completion side effects at finish.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_if_done    <= 1'b0;
            r_d_done     <= 1'b0;
            r_rdata      <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_err        <= 1'b0;
            r_last_grant <= GRANT_FETCH;
        end else begin
            r_if_done <= 1'b0;
            r_d_done  <= 1'b0;
            if (w_grant) begin
                r_mem_en     <= 1'b1;
                r_last_grant <= w_sel;
                if (w_sel == GRANT_DATA) begin
                    r_mem_we    <= d_we;
                    r_mem_addr  <= d_addr;
                    r_mem_wdata <= d_wdata;
                end else begin
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= if_addr;
                    r_mem_wdata <= '0;
                end
            end else if (w_finish) begin
                r_mem_en <= 1'b0;
                r_mem_we <= 1'b0;
                if (r_state == ST_DATA) begin
                    r_d_done <= 1'b1;
                end else begin
                    r_if_done <= 1'b1;
                end
                if (w_timeout) begin
                    r_err <= 1'b1;
                end else if (!r_mem_we) begin
                    r_rdata <= mem_rdata;
                end else begin
                    r_rdata <= r_rdata;
                end
            end else begin
                r_mem_en <= r_mem_en;
            end
        end
    end

    assign if_done   = r_if_done;
    assign d_done    = r_d_done;
    assign rdata     = r_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign err       = r_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios with literal
// expectations plus randomized traffic, all compared every cycle against a
// transaction-level model of the arbiter.
module tb_mem_port_arbiter;

    localparam int DW      = 32;
    localparam int AW      = 32;
    localparam int TIMEOUT = 15;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          if_done;
    logic          d_done;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ready;
    logic          err;

    int n_checks = 0;
    int n_fail   = 0;

    mem_port_arbiter #(.DW(DW), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .if_done   (if_done),
        .d_done    (d_done),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .err       (err)
    );

    always #5 clk = ~clk;

    // Transaction-level model: one outstanding access with its age.
    bit            m_busy;
    bit            m_is_data;
    int            m_age;
    logic [AW-1:0] m_addr;
    bit            m_we;
    logic [DW-1:0] m_wdata;
    logic [DW-1:0] m_rdata;
    bit            m_err;
    bit            m_last_data;
    bit            m_if_done;
    bit            m_d_done;

    task automatic model_reset();
        m_busy      = 1'b0;
        m_is_data   = 1'b0;
        m_age       = 0;
        m_addr      = '0;
        m_we        = 1'b0;
        m_wdata     = '0;
        m_rdata     = '0;
        m_err       = 1'b0;
        m_last_data = 1'b0;
        m_if_done   = 1'b0;
        m_d_done    = 1'b0;
    endtask

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        bit nif;
        bit nd;
        nif = 1'b0;
        nd  = 1'b0;
        if (!reset) begin
            model_reset();
        end else if (m_busy) begin
            // Ages 0..TIMEOUT are allowed; ready on any of them is success.
            if (mem_ready || m_age == TIMEOUT) begin
                if (!mem_ready) m_err = 1'b1;
                else if (!m_we) m_rdata = mem_rdata;
                if (m_is_data) nd = 1'b1; else nif = 1'b1;
                m_busy = 1'b0;
            end else begin
                m_age = m_age + 1;
            end
            m_if_done = nif;
            m_d_done  = nd;
        end else begin
            if (!m_if_done && !m_d_done && (if_req || d_req)) begin
                if (if_req && d_req) m_is_data = !m_last_data;
                else                 m_is_data = d_req;
                m_last_data = m_is_data;
                m_busy  = 1'b1;
                m_age   = 0;
                m_addr  = m_is_data ? d_addr : if_addr;
                m_we    = m_is_data ? d_we : 1'b0;
                m_wdata = d_wdata;
            end
            m_if_done = 1'b0;
            m_d_done  = 1'b0;
        end
    endtask

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        check("if_done", if_done, m_if_done);
        check("d_done",  d_done,  m_d_done);
        check("mem_en",  mem_en,  m_busy);
        check("err",     err,     m_err);
        check("rdata",   rdata,   m_rdata);
        if (m_busy) begin
            check("mem_addr", mem_addr, m_addr);
            check("mem_we",   mem_we,   m_we);
            if (m_we) check("mem_wdata", mem_wdata, m_wdata);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        #1;
        model_reset();
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        int pct;
        reset = 1'b0;
        idle_inputs();
        model_reset();
        do_reset();
        check("rst_mem_en", mem_en, 1'b0);
        check("rst_rdata",  rdata,  32'h0);
        check("rst_err",    err,    1'b0);
        check("rst_done",   {if_done, d_done}, 2'b00);
        check("rst_cmd",    {mem_we, mem_addr, mem_wdata}, 65'h0);

        // Contention from reset: data first, then fetch, then data again.
        if_req = 1'b1; if_addr = 32'hA0;
        d_req  = 1'b1; d_we = 1'b0; d_addr = 32'hB0;
        mem_ready = 1'b1; mem_rdata = 32'h11;
        step(); check("ct1_addr", {mem_en, mem_addr}, {1'b1, 32'hB0});
        step(); check("ct2_ddone", d_done, 1'b1);
        step(); check("ct3_hold", mem_en, 1'b0);
        step(); check("ct4_addr", {mem_en, mem_addr}, {1'b1, 32'hA0});
        step(); check("ct5_ifdone", if_done, 1'b1);
        step();
        step(); check("ct7_addr", {mem_en, mem_addr}, {1'b1, 32'hB0});
        step(); check("ct8_ddone", d_done, 1'b1);
        if_req = 1'b0; d_req = 1'b0;
        step(); step();

        // Zero-wait read.
        if_req = 1'b1; if_addr = 32'h40; mem_ready = 1'b1; mem_rdata = 32'hDEADBEEF;
        step(); check("zw_cmd", {mem_en, mem_we, mem_addr}, {1'b1, 1'b0, 32'h40});
        step(); check("zw_done", {if_done, rdata}, {1'b1, 32'hDEADBEEF});
        check("zw_en_off", mem_en, 1'b0);
        if_req = 1'b0;
        step(); check("zw_pulse", if_done, 1'b0);

        // Three-wait store; requester inputs change after grant.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h100; d_wdata = 32'h12345678;
        mem_ready = 1'b0; mem_rdata = 32'h00000BAD;
        step();
        d_addr = 32'h999; d_wdata = 32'h0; d_we = 1'b0;
        for (int k = 0; k < 4; k++) begin
            mem_ready = (k == 3);
            check("st_cmd", {mem_en, mem_we, mem_addr, mem_wdata},
                  {1'b1, 1'b1, 32'h100, 32'h12345678});
            check("st_nodone", d_done, 1'b0);
            step();
        end
        check("st_done", {d_done, mem_en, rdata}, {1'b1, 1'b0, 32'hDEADBEEF});
        d_req = 1'b0; mem_ready = 1'b0;
        step(); check("st_once", d_done, 1'b0);

        // Timeout with mem_ready never asserted.
        if_req = 1'b1; if_addr = 32'h200;
        step();
        for (int k = 0; k <= TIMEOUT; k++) begin
            check("to_wait", {mem_en, if_done, err}, 3'b100);
            step();
        end
        check("to_done", {if_done, err, mem_en, rdata}, {1'b1, 1'b1, 1'b0, 32'hDEADBEEF});
        if_req = 1'b0;
        step(); check("to_sticky", {err, if_done}, 2'b10);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
        step(); check("to_next_en", {mem_en, mem_addr}, {1'b1, 32'h300});
        step(); check("to_next_done", {d_done, rdata, err}, {1'b1, 32'hCAFEF00D, 1'b1});
        d_req = 1'b0;
        step();

        // Ready first seen on the last allowed cycle.
        do_reset();
        if_req = 1'b1; if_addr = 32'h44; mem_rdata = 32'h5A5A5A5A;
        step();
        for (int k = 0; k <= TIMEOUT; k++) begin
            mem_ready = (k == TIMEOUT);
            check("bd_wait", {mem_en, if_done}, 2'b10);
            step();
        end
        check("bd_done", {if_done, err, rdata}, {1'b1, 1'b0, 32'h5A5A5A5A});
        if_req = 1'b0; mem_ready = 1'b0;
        step();

        // Reset during a data access.
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h80; d_wdata = 32'h77;
        step(); step(); step();
        check("rm_busy", mem_en, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        check("rm_en_now", mem_en, 1'b0);
        compare_all();
        step(); check("rm_nodone", {if_done, d_done}, 2'b00);
        step();
        idle_inputs();
        reset = 1'b1;
        step(); check("rm_outs", {mem_en, mem_we, mem_addr, mem_wdata, rdata, err, if_done, d_done},
                      100'h0);

        // Randomized traffic at several memory-ready rates.
        for (int ph = 0; ph < 4; ph++) begin
            pct = (ph == 0) ? 90 : (ph == 1) ? 50 : (ph == 2) ? 20 : 3;
            for (int c = 0; c < 700; c++) begin
                if (!if_req) if_req = ($urandom_range(0, 3) == 0);
                else if (m_if_done) if_req = $urandom_range(0, 1);
                if (!d_req) d_req = ($urandom_range(0, 3) == 0);
                else if (m_d_done) d_req = $urandom_range(0, 1);
                if ($urandom_range(0, 7) == 0) if_addr = $urandom;
                if ($urandom_range(0, 7) == 0) begin
                    d_addr  = $urandom;
                    d_wdata = $urandom;
                    d_we    = $urandom_range(0, 1);
                end
                mem_ready = ($urandom_range(0, 99) < pct);
                mem_rdata = $urandom;
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter DW, default 32: data width.
REQ-002 SHALL have parameter AW, default 32: address width.
REQ-003 SHALL have parameter TIMEOUT, default 15: maximum wait cycles per access, range 1..255.
REQ-004 SHALL have port clk  in  1: single clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1: asynchronous, active-low reset.
REQ-006 SHALL have ports if_req in 1 and if_addr in AW: instruction-fetch request, level, held until if_done.
REQ-007 SHALL have ports d_req in 1, d_we in 1, d_addr in AW, d_wdata in DW: data load/store request, level, held until d_done.
REQ-008 SHALL have ports if_done out 1 and d_done out 1: one-cycle completion pulses.
REQ-009 SHALL have port rdata  out  DW: registered memory data, the value of the last completed read.
REQ-010 SHALL have ports mem_en, mem_we (out 1), mem_addr (out AW), mem_wdata (out DW): single memory port.
REQ-011 SHALL have ports mem_rdata (in DW) and mem_ready (in 1): memory read data and access-complete.
REQ-012 SHALL have port err  out  1: sticky timeout flag.

Function
REQ-013 SHALL implement FSM states IDLE, FETCH, DATA.
REQ-014 SHALL, in IDLE with done low, grant on the next edge: only if_req -> FETCH; only d_req -> DATA; both -> the requester not granted last (last_grant flag).
REQ-015 SHALL not grant in any IDLE cycle where if_done or d_done is high.
REQ-016 SHALL latch the granted address, write enable and write data at grant; later requester input changes are ignored until completion.
REQ-017 SHALL drive mem_en=1 and registered mem_addr/mem_we/mem_wdata for every cycle in FETCH/DATA; mem_we=0 in FETCH; mem_en=0 in IDLE.
REQ-018 SHALL sample mem_ready in every FETCH/DATA cycle, including the first.
REQ-019 SHALL, on mem_ready, return to IDLE and pulse the matching done for one cycle on the next edge; on a read, rdata <= mem_rdata on the same edge.
REQ-020 SHALL leave rdata unchanged on a write and on a timeout.
REQ-021 SHALL give minimum latency of req sampled at cycle 0 -> mem_en cycle 1 -> done and rdata valid cycle 2.
REQ-022 SHALL count wait cycles, starting at 0 on grant, and abort when the count reaches TIMEOUT without mem_ready: set err, pulse done, return to IDLE.
REQ-023 SHALL treat mem_ready on the cycle the count reaches TIMEOUT as success (ready wins).
REQ-024 SHALL ignore mem_ready while in IDLE.
REQ-025 SHALL keep err set until reset.

Reset
REQ-026 SHALL, while reset=0 and asynchronously: state=IDLE, all outputs 0, rdata=0, err=0, counter=0, last_grant=FETCH (data wins first contention).
REQ-027 SHALL, on reset asserted mid-access, drop mem_en immediately and issue no done pulse.

Structure
REQ-028 SHALL place the state enum, last-grant encoding and DW/AW/TIMEOUT defaults in shared package mem_arb_pkg.
REQ-029 SHALL implement the wait counter as sub-module wait_timer (clear, enable, TIMEOUT compare, 8-bit).

Verification
REQ-030 SHALL cover zero-wait read: if_req, if_addr=0x40, mem_ready=1 with mem_rdata=0xDEADBEEF -> mem_en cycle 1, if_done and rdata=0xDEADBEEF cycle 2.
REQ-031 SHALL cover contention: if_req and d_req together from reset -> DATA granted first, FETCH next, and alternation continues while both are held.
REQ-032 SHALL cover a 3-wait store: d_we=1, d_addr=0x100, d_wdata=0x12345678, mem_ready on the 4th mem_en cycle -> mem_we=1 throughout, d_done once, rdata unchanged.
REQ-033 SHALL cover timeout: TIMEOUT=15, mem_ready never asserted -> done pulses after 15 wait cycles, err=1 and stays 1, the next request is served normally.
REQ-034 SHALL cover boundary ready: mem_ready first asserted on the cycle the count reaches TIMEOUT -> normal completion, err=0.
REQ-035 SHALL cover reset mid-access: reset=0 during DATA -> mem_en=0 immediately, no done pulse, every output 0 afterwards.
